// File: rtl/inst_buffer_pkg.sv
// Shared frontend constants and bundles used by the instruction buffer.
package inst_buffer_pkg;

    localparam int unsigned DEF_BLOCK_INST_SIZE = 8;
    localparam int unsigned DEF_FETCH_WIDTH     = 4;
    localparam int unsigned DEF_FSQ_WIDTH       = 4;

    localparam int unsigned IBUF_DEPTH     = 32;
    localparam int unsigned IBUF_CNT_WIDTH = $clog2(IBUF_DEPTH) + 1;

    typedef struct packed {
        logic [31:0]              inst;
        logic [DEF_FSQ_WIDTH-1:0] fsq_idx;
    } IBufEntry;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ibuf_ram.sv
// Circular instruction storage: masked multi-port write from a base address,
// multi-port combinational read from a base address, all offsets mod DEPTH.
module ibuf_ram #(
    parameter int unsigned BLOCK_INST_SIZE = 8,
    parameter int unsigned FETCH_WIDTH     = 4,
    parameter int unsigned DEPTH           = 32,
    parameter int unsigned FSQ_WIDTH       = 4,
    localparam int unsigned PtrW           = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic [BLOCK_INST_SIZE-1:0]       wr_en_i,
    input  logic [PtrW-1:0]                  wr_base_i,
    input  logic [BLOCK_INST_SIZE*32-1:0]    wr_inst_i,
    input  logic [FSQ_WIDTH-1:0]             wr_fsq_idx_i,
    input  logic [PtrW-1:0]                  rd_base_i,
    output logic [FETCH_WIDTH*32-1:0]        rd_inst_o,
    output logic [FETCH_WIDTH*FSQ_WIDTH-1:0] rd_fsq_idx_o
);

    typedef struct packed {
        logic [31:0]          inst;
        logic [FSQ_WIDTH-1:0] fsq_idx;
    } entry_t;

    entry_t          mem_q   [DEPTH];
    logic [PtrW-1:0] wr_addr [BLOCK_INST_SIZE];
    logic [PtrW-1:0] rd_addr [FETCH_WIDTH];

    // Pointer-width addition wraps naturally since DEPTH is a power of two.
    always_comb begin
        for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
            wr_addr[i] = wr_base_i + PtrW'(i);
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            rd_addr[i] = rd_base_i + PtrW'(i);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
            if (wr_en_i[i]) begin
                mem_q[wr_addr[i]] <= '{inst: wr_inst_i[i*32 +: 32], fsq_idx: wr_fsq_idx_i};
            end
        end
    end

    always_comb begin
        rd_inst_o    = '0;
        rd_fsq_idx_o = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            rd_inst_o[i*32 +: 32]                  = mem_q[rd_addr[i]].inst;
            rd_fsq_idx_o[i*FSQ_WIDTH +: FSQ_WIDTH] = mem_q[rd_addr[i]].fsq_idx;
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer between predecode and decode: pointer, occupancy,
// back-pressure and redirect-flush control around the ibuf_ram storage.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned BLOCK_INST_SIZE = DEF_BLOCK_INST_SIZE,
    parameter int unsigned FETCH_WIDTH     = DEF_FETCH_WIDTH,
    parameter int unsigned DEPTH           = IBUF_DEPTH,
    parameter int unsigned FSQ_WIDTH       = DEF_FSQ_WIDTH,
    localparam int unsigned NumW           = $clog2(BLOCK_INST_SIZE) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [BLOCK_INST_SIZE-1:0]       in_en,
    input  logic [NumW-1:0]                  in_num,
    input  logic [BLOCK_INST_SIZE*32-1:0]    in_inst,
    input  logic [FSQ_WIDTH-1:0]             in_fsqIdx,
    input  logic                             redirect,
    input  logic                             stall,
    output logic                             ibuf_full,
    output logic [FETCH_WIDTH-1:0]           out_en,
    output logic [FETCH_WIDTH*32-1:0]        out_inst,
    output logic [FETCH_WIDTH*FSQ_WIDTH-1:0] out_fsqIdx
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full_q, full_d;

    logic                       wr_accept;
    logic [CntW-1:0]            acc_num;
    logic [CntW-1:0]            deq_num;
    logic [BLOCK_INST_SIZE-1:0] wr_en;

    always_comb begin
        wr_accept = !full_q && !redirect;
        acc_num   = wr_accept ? CntW'(in_num) : '0;
        deq_num   = stall ? '0 : CntW'(min_u(32'(count_q), FETCH_WIDTH));
        wr_en     = in_en & {BLOCK_INST_SIZE{wr_accept}};

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        full_d  = full_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            full_d  = 1'b0;
        end else begin
            head_d  = head_q + deq_num[PtrW-1:0];
            tail_d  = tail_q + acc_num[PtrW-1:0];
            count_d = count_q + acc_num - deq_num;
            // Judged on next occupancy so a clear flag always leaves room for a whole block.
            full_d  = (CntW'(DEPTH) - count_d) < CntW'(BLOCK_INST_SIZE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            out_en[i] = count_q > CntW'(i);
        end
    end

    assign ibuf_full = full_q;

    ibuf_ram #(
        .BLOCK_INST_SIZE (BLOCK_INST_SIZE),
        .FETCH_WIDTH     (FETCH_WIDTH),
        .DEPTH           (DEPTH),
        .FSQ_WIDTH       (FSQ_WIDTH)
    ) u_ram (
        .clk          (clk),
        .wr_en_i      (wr_en),
        .wr_base_i    (tail_q),
        .wr_inst_i    (in_inst),
        .wr_fsq_idx_i (in_fsqIdx),
        .rd_base_i    (head_q),
        .rd_inst_o    (out_inst),
        .rd_fsq_idx_o (out_fsqIdx)
    );

    in_num_matches_en: assert property (@(posedge clk) disable iff (rst)
        in_num == NumW'($countones(in_en)));

    no_write_when_full: assert property (@(posedge clk) disable iff (rst)
        !(full_q && in_num != '0));

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized bench for inst_buffer against a queue-based reference model.
module tb_inst_buffer;

    localparam int B   = 8;
    localparam int FW  = 4;
    localparam int D   = 32;
    localparam int FSQ = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [B-1:0]     in_en;
    logic [3:0]       in_num;
    logic [B*32-1:0]  in_inst;
    logic [FSQ-1:0]   in_fsqIdx;
    logic             redirect;
    logic             stall;
    logic             ibuf_full;
    logic [FW-1:0]    out_en;
    logic [FW*32-1:0] out_inst;
    logic [FW*FSQ-1:0] out_fsqIdx;

    inst_buffer #(
        .BLOCK_INST_SIZE (B),
        .FETCH_WIDTH     (FW),
        .DEPTH           (D),
        .FSQ_WIDTH       (FSQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_en      (in_en),
        .in_num     (in_num),
        .in_inst    (in_inst),
        .in_fsqIdx  (in_fsqIdx),
        .redirect   (redirect),
        .stall      (stall),
        .ibuf_full  (ibuf_full),
        .out_en     (out_en),
        .out_inst   (out_inst),
        .out_fsqIdx (out_fsqIdx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: FIFO of {inst, fsqIdx} plus the registered full flag.
    logic [35:0] model_q[$];
    logic        model_full;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        int n = model_q.size();
        int v = (n < FW) ? n : FW;
        logic [FW-1:0] exp_en = FW'((1 << v) - 1);
        check_eq("out_en", 64'(out_en), 64'(exp_en));
        check_eq("ibuf_full", 64'(ibuf_full), 64'(model_full));
        for (int i = 0; i < v; i++) begin
            check_eq($sformatf("inst%0d", i), 64'(out_inst[i*32 +: 32]), 64'(model_q[i][35:4]));
            check_eq($sformatf("fsq%0d", i), 64'(out_fsqIdx[i*FSQ +: FSQ]),
                     64'(model_q[i][3:0]));
        end
    endtask

    task automatic model_update();
        if (redirect) begin
            model_q.delete();
            model_full = 1'b0;
        end else begin
            int n   = model_q.size();
            int deq = stall ? 0 : ((n < FW) ? n : FW);
            for (int i = 0; i < deq; i++) void'(model_q.pop_front());
            if (!model_full) begin
                for (int i = 0; i < int'(in_num); i++) begin
                    model_q.push_back({in_inst[i*32 +: 32], in_fsqIdx});
                end
            end
            model_full = (D - model_q.size()) < B;
        end
    endtask

    task automatic set_write(input int num, input logic [FSQ-1:0] fsq);
        in_num    = 4'(num);
        in_en     = B'((1 << num) - 1);
        in_fsqIdx = fsq;
        for (int i = 0; i < B; i++) in_inst[i*32 +: 32] = $urandom;
    endtask

    task automatic set_idle();
        in_num   = '0;
        in_en    = '0;
        in_inst  = '0;
        redirect = 1'b0;
    endtask

    // Called just after a falling edge: check, clock, update model, return at next fall.
    task automatic tick();
        compare_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    int stall_pct;

    initial begin
        rst = 1'b1;
        set_idle();
        in_fsqIdx  = '0;
        stall      = 1'b0;
        model_full = 1'b0;
        #2;
        check_eq("rst_out_en", 64'(out_en), 64'h0);
        check_eq("rst_full", 64'(ibuf_full), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic write of three, then empty again.
        set_write(3, 4'd5);
        in_inst[31:0] = 32'h11; in_inst[63:32] = 32'h22; in_inst[95:64] = 32'h33;
        tick();
        set_idle();
        check_eq("basic_en", 64'(out_en), 64'h7);
        check_eq("basic_i0", 64'(out_inst[31:0]), 64'h11);
        check_eq("basic_i2", 64'(out_inst[95:64]), 64'h33);
        check_eq("basic_f1", 64'(out_fsqIdx[7:4]), 64'h5);
        tick();
        check_eq("basic_drained", 64'(out_en), 64'h0);

        // Fill under stall, then drain.
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_write(B, 4'(k + 1));
            tick();
        end
        set_idle();
        check_eq("fill_full", 64'(ibuf_full), 64'h1);
        stall = 1'b0;
        for (int k = 0; k < 9; k++) tick();

        // Redirect with a concurrent write discards both.
        stall = 1'b1;
        set_write(8, 4'd3); tick();
        set_write(2, 4'd4); tick();
        set_write(8, 4'd6); redirect = 1'b1; tick();
        set_idle();
        check_eq("redir_en", 64'(out_en), 64'h0);
        set_write(1, 4'd7); tick();
        set_idle();
        check_eq("post_redir_en", 64'(out_en), 64'h1);
        stall = 1'b0;
        tick();

        // Randomized traffic: varying stall pressure, occasional redirect.
        stall_pct = 10;
        for (int c = 0; c < 800; c++) begin
            if (c % 50 == 0) stall_pct = (c % 150 == 0) ? 10 : ((c % 100 == 0) ? 60 : 90);
            set_idle();
            if (!model_full) set_write($urandom_range(0, B), 4'($urandom));
            stall    = ($urandom_range(0, 99) < stall_pct);
            redirect = ($urandom_range(0, 39) == 0);
            tick();
        end

        // Asynchronous reset between edges with data present.
        set_idle();
        stall = 1'b1;
        set_write(6, 4'd9); tick();
        set_idle();
        #2 rst = 1'b1;
        #1;
        check_eq("async_en", 64'(out_en), 64'h0);
        check_eq("async_full", 64'(ibuf_full), 64'h0);
        model_q.delete();
        model_full = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        set_write(2, 4'd1); tick();
        set_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Instruction buffer between predecode and decode: the receiving end of the predecode-to-instruction-buffer channel.
- Accepts up to BLOCK_INST_SIZE packed instructions per cycle, each tagged with its fetch-stream index, into a circular queue.
- Presents up to FETCH_WIDTH oldest instructions per cycle to decode.
- Raises ibuf_full back-pressure to the frontend and flushes on frontend redirect.

## Interface
Parameters:
- BLOCK_INST_SIZE, 8, max instructions written per cycle
- FETCH_WIDTH, 4, max instructions read per cycle
- DEPTH, 32, queue entries; power of two, ≥ 2*BLOCK_INST_SIZE
- FSQ_WIDTH, 4, fetch-stream index width

Ports:
- clk  in  1  clock, single domain
- rst  in  1  asynchronous, active-high reset
- in_en  in  BLOCK_INST_SIZE  write valid mask; contiguous from bit 0
- in_num  in  $clog2(BLOCK_INST_SIZE)+1  popcount of in_en
- in_inst  in  BLOCK_INST_SIZE×32  instructions, slot 0 oldest
- in_fsqIdx  in  FSQ_WIDTH  stream index for all slots of this write
- redirect  in  1  frontend/backend redirect; flush all contents
- stall  in  1  decode cannot accept this cycle
- ibuf_full  out  1  free entries < BLOCK_INST_SIZE; registered
- out_en  out  FETCH_WIDTH  read valid mask, contiguous from bit 0
- out_inst  out  FETCH_WIDTH×32  oldest instructions, slot 0 oldest
- out_fsqIdx  out  FETCH_WIDTH×FSQ_WIDTH  per-slot stream index

## Operation
State:
- head, tail: $clog2(DEPTH) bits, wrap modulo DEPTH
- count: $clog2(DEPTH)+1 bits
- storage: DEPTH × {inst[31:0], fsqIdx}

Write:
- Slot i (i < in_num) is written to entry (tail+i) mod DEPTH.
- tail advances by in_num.
- The write is accepted only when ibuf_full=0 and redirect=0.

Read:
- out_en[i] = (count > i) for i < FETCH_WIDTH.
- out_inst[i] and out_fsqIdx[i] come from entry (head+i) mod DEPTH.
- deq_num = stall ? 0 : min(count, FETCH_WIDTH). head advances by deq_num.

Count and full:
- count_next = count + accepted in_num − deq_num.
- ibuf_full register = (DEPTH − count_next) < BLOCK_INST_SIZE.
- Because ibuf_full is computed from count_next, any cycle with ibuf_full=0 guarantees room for a full write, regardless of that cycle's dequeue.

Redirect:
- At the next edge: head=tail=count=0, ibuf_full=0.
- The same-cycle write and dequeue are discarded.

Protocol errors:
- in_num>0 while ibuf_full=1 is illegal: data is dropped and a simulation assertion fires.
- in_num ≠ popcount(in_en) is illegal and asserted.

Wrap-around:
- Writes and reads spanning entry DEPTH−1 → 0 are split transparently.
- Order is preserved.

## Timing
- Reset (async assert): head=tail=count=0, ibuf_full=0, out_en=0; out_inst/out_fsqIdx are don't-care.
- Write-to-read latency is 1 cycle: data written at edge N appears on out_* in cycle N+1 when it is the oldest.
- Read outputs are combinational from head/count/storage; no output register.
- Decode samples out_* in any cycle with stall=0. Those instructions are consumed at that edge.
- ibuf_full changes only at clock edges. Predecode must observe it in the same cycle it drives in_en.
- Simultaneous write and read in one cycle are both applied; count reflects both.
- Redirect has priority over write, read and full. The first post-redirect write is accepted in the cycle after the redirect.

## Structure
- Shared package: IBUF_DEPTH and IBUF_CNT_WIDTH constants; an IBufEntry typedef {inst, fsqIdx} next to the other frontend bundles. BLOCK_INST_SIZE, FETCH_WIDTH and FSQ_WIDTH come from the existing global defines.
- One natural sub-module, ibuf_ram:
  - DEPTH-entry storage with BLOCK_INST_SIZE write ports (base address plus mask) and FETCH_WIDTH read ports (base address).
  - Per-port address offsets computed internally, mod DEPTH.
- inst_buffer holds the pointers, count, full and redirect logic.
- Port list maps onto the instbuffer modport of the predecode-ibuffer interface, plus the FrontendCtrl ibuf_full/redirect signals.

## Test plan
- **Reset:** after rst, out_en=0 and ibuf_full=0. Write 3 insts (0x11,0x22,0x33, fsqIdx=5) with stall=0 → next cycle out_en=4'b0111, out_inst slots {0x11,0x22,0x33}, out_fsqIdx all 5; following cycle out_en=0.
- **Fill:** stall=1 with four full 8-inst writes. After the 2nd write count=16, ibuf_full=0; after the 3rd count=24 (free=8), ibuf_full=0; 4th write accepted, count=32, ibuf_full=1. Release stall → 4 insts/cycle drained in write order; ibuf_full falls the cycle after count_next ≤ 24.
- **Wrap-around:** preload so head=tail=28. Write 8 insts → entries 28..31,0..3. Reads return them in order with correct per-slot fsqIdx.
- **Simultaneous:** count=6, stall=0, write 5 → deq 4, count_next=7; out_en=1111 both cycles.
- **Redirect:** count=10 with redirect and an 8-inst write in the same cycle → next cycle count=0, out_en=0, ibuf_full=0. The write is lost; a write the cycle after appears normally.
- **Async reset:** assert rst mid-stream between clock edges → outputs go to reset values immediately, with no edge needed.
